// File: rtl/interval_counter_arbiter_pkg.sv
// Shared types and constants for the interval counter arbiter.
package interval_counter_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned REQ0 = 0;
  localparam int unsigned REQ1 = 1;

  // Reset owner is requester 1, so requester 0 wins the first contested arbitration.
  localparam logic LAST_GRANT_RST = 1'b1;

  // Round-robin pick between two requesters; assumes at least one req bit is set.
  function automatic logic pick_winner(input logic [1:0] req, input logic last);
    if (req[REQ0] && req[REQ1]) return ~last;
    return req[REQ1];
  endfunction

endpackage

// File: rtl/interval_counter_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface interval_counter_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic [1:0]       req;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic [1:0]       grant;
  logic [1:0]       done;
  logic             busy;
  logic [WIDTH-1:0] count;

  modport master (
    output req, len0, len1,
    input  grant, done, busy, count
  );

  modport slave (
    input  req, len0, len1,
    output grant, done, busy, count
  );
endinterface

// File: rtl/interval_counter_arbiter_tick.sv
// interval_tick_counter: WIDTH-bit up counter with clear/enable and terminal flag.
module interval_tick_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_len_q,
  output logic [WIDTH-1:0] o_count,
  output logic             o_terminal
);

  logic [WIDTH-1:0] r_count;

  // Clear has priority over enable; the count never wraps because the FSM stops at len_q.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count    = r_count;
  assign o_terminal = (r_count == i_len_q);

endmodule

// File: rtl/interval_counter_arbiter.sv
// Round-robin arbiter sharing one interval counter between two requesters.
// Optional feature: define INTERVAL_ABORT_EN to let the owner cancel its
// interval by dropping req during COUNT (no done pulse in that case).
module interval_counter_arbiter
  import interval_counter_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  interval_counter_arbiter_if.slave   bus
);

  state_t           r_state;
  logic [1:0]       r_grant;
  logic [1:0]       r_done;
  logic             r_busy;
  logic             r_last;
  logic             r_owner;
  logic [WIDTH-1:0] r_len_q;

  logic             w_winner;
  logic             w_abort;
  logic             w_enable;
  logic             w_clear;
  logic             w_terminal;
  logic [WIDTH-1:0] w_count;

  // Arbitration winner, abort detection and counter control.
  always_comb begin
    w_winner = pick_winner(bus.req, r_last);
`ifdef INTERVAL_ABORT_EN
    w_abort  = (r_state == COUNT) && !bus.req[r_owner];
`else
    w_abort  = 1'b0;
`endif
    // Counter only advances mid-interval; everywhere else it is held at zero,
    // which keeps count at 0 outside COUNT without a separate output register.
    w_enable = (r_state == COUNT) && !w_terminal && !w_abort;
    w_clear  = !w_enable;
  end

  interval_tick_counter #(
    .WIDTH (WIDTH)
  ) u_tick (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_enable   (w_enable),
    .i_len_q    (r_len_q),
    .o_count    (w_count),
    .o_terminal (w_terminal)
  );

  // Sequencing FSM with registered grant/done/busy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_last  <= LAST_GRANT_RST;
      r_owner <= 1'b0;
      r_len_q <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (|bus.req) begin
            r_owner           <= w_winner;
            r_len_q           <= w_winner ? bus.len1 : bus.len0;
            r_grant           <= '0;
            r_grant[w_winner] <= 1'b1;
            r_busy            <= 1'b1;
            r_state           <= COUNT;
          end
        end
        COUNT: begin
          if (w_abort) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_last  <= r_owner;
            r_state <= IDLE;
          end else if (w_terminal) begin
            r_grant          <= '0;
            r_done[r_owner]  <= 1'b1;
            r_state          <= DONE;
          end
        end
        DONE: begin
          r_last  <= r_owner;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant = r_grant;
  assign bus.done  = r_done;
  assign bus.busy  = r_busy;
  assign bus.count = w_count;

endmodule

// File: tb/tb_interval_counter_arbiter.sv
// Testbench for interval_counter_arbiter: directed scenarios plus randomized
// handshaking requesters, all checked against an interval-timeline model.
module tb_interval_counter_arbiter;

  localparam int unsigned WIDTH = 4;

  logic clock;
  logic reset;

  interval_counter_arbiter_if #(.WIDTH(WIDTH)) bus ();

  interval_counter_arbiter #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: each granted interval is a record on an absolute edge timeline.
  int   cyc     = 0;
  bit   m_has   = 0;
  int   m_start = 0;
  int   m_len   = 0;
  int   m_abort = -1;
  logic m_owner = 1'b0;
  logic [1:0] m_exp_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    else
      n_pass++;
  endtask

  // Apply the inputs seen at edge 'cyc' to the interval timeline.
  task automatic model_edge(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1);
    bit   free;
    logic last;
    logic win;
`ifdef INTERVAL_ABORT_EN
    if (m_has && m_abort < 0 && cyc >= m_start + 1 && cyc <= m_start + m_len + 1 && !r[m_owner])
      m_abort = cyc;
`endif
    if (!m_has)          free = 1;
    else if (m_abort >= 0) free = (cyc >= m_abort + 1);
    else                 free = (cyc >= m_start + m_len + 3);
    if (free && r != 2'b00) begin
      last = m_has ? m_owner : 1'b1;
      win  = (r == 2'b11) ? ~last : r[1];
      m_has   = 1;
      m_start = cyc;
      m_len   = win ? int'(l1) : int'(l0);
      m_owner = win;
      m_abort = -1;
    end
  endtask

  task automatic check_outputs();
    logic [1:0] g, d;
    logic       b;
    logic [3:0] c;
    g = '0; d = '0; b = 1'b0; c = '0;
    if (m_has && !(m_abort >= 0 && cyc >= m_abort)) begin
      if (cyc <= m_start + m_len) begin
        g[m_owner] = 1'b1; b = 1'b1; c = 4'(cyc - m_start);
      end else if (cyc == m_start + m_len + 1) begin
        d[m_owner] = 1'b1; b = 1'b1;
      end
    end
    m_exp_done = d;
    check("grant", 32'(bus.grant), 32'(g));
    check("done",  32'(bus.done),  32'(d));
    check("busy",  32'(bus.busy),  32'(b));
    check("count", 32'(bus.count), 32'(c));
  endtask

  task automatic step(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1);
    bus.req  = r;
    bus.len0 = l0;
    bus.len1 = l1;
    @(posedge clock);
    cyc++;
    model_edge(r, l0, l1);
    #1;
    check_outputs();
  endtask

  // Async reset applied between edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    bus.req = 2'b00;
    reset = 1'b1;
    #1;
    check({tag, "_grant"}, 32'(bus.grant), 32'd0);
    check({tag, "_done"},  32'(bus.done),  32'd0);
    check({tag, "_busy"},  32'(bus.busy),  32'd0);
    check({tag, "_count"}, 32'(bus.count), 32'd0);
    @(posedge clock);
    cyc++;
    m_has = 0;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] rq;
    logic [3:0] l0, l1;
    reset    = 1'b1;
    bus.req  = 2'b00;
    bus.len0 = '0;
    bus.len1 = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    reset = 1'b0;

    // Single request, len0 = 3.
    step(2'b01, 4'd3, 4'd0);
    check("t1_grant_c1", 32'(bus.grant), 32'd1);
    for (int unsigned i = 0; i < 3; i++) step(2'b01, 4'd3, 4'd0);
    check("t1_count_c4", 32'(bus.count), 32'd3);
    step(2'b01, 4'd3, 4'd0);
    check("t1_done_c5", 32'(bus.done), 32'd1);
    step(2'b00, 4'd3, 4'd0);
    check("t1_busy_c6", 32'(bus.busy), 32'd0);
    step(2'b00, 4'd3, 4'd0);

    // Simultaneous requests: requester 0 first, then requester 1.
    do_reset("t2");
    for (int unsigned i = 0; i < 3; i++) step(2'b11, 4'd1, 4'd2);
    check("t2_done0", 32'(bus.done), 32'd1);
    step(2'b10, 4'd1, 4'd2);
    step(2'b10, 4'd1, 4'd2);
    check("t2_grant1", 32'(bus.grant), 32'd2);
    for (int unsigned i = 0; i < 3; i++) step(2'b10, 4'd1, 4'd2);
    check("t2_done1", 32'(bus.done), 32'd2);
    step(2'b00, 4'd1, 4'd2);

    // Boundary lengths: 0 and the full 2^WIDTH-1.
    do_reset("t3");
    step(2'b01, 4'd0, 4'd15);
    step(2'b01, 4'd0, 4'd15);
    check("t3_done0_len0", 32'(bus.done), 32'd1);
    step(2'b00, 4'd0, 4'd15);
    for (int unsigned i = 0; i < 16; i++) step(2'b10, 4'd0, 4'd15);
    check("t3_count_max", 32'(bus.count), 32'd15);
    step(2'b10, 4'd0, 4'd15);
    check("t3_done1_len15", 32'(bus.done), 32'd2);
    step(2'b00, 4'd0, 4'd15);

    // Reset during COUNT.
    do_reset("t4a");
    for (int unsigned i = 0; i < 4; i++) step(2'b01, 4'd5, 4'd0);
    check("t4_count3", 32'(bus.count), 32'd3);
    do_reset("t4b");
    for (int unsigned i = 0; i < 8; i++) step(2'b00, 4'd5, 4'd0);
    step(2'b11, 4'd1, 4'd1);
    check("t4_regrant0", 32'(bus.grant), 32'd1);
    for (int unsigned i = 0; i < 2; i++) step(2'b11, 4'd1, 4'd1);
    step(2'b00, 4'd1, 4'd1);

    // Owner drops req mid-interval.
    do_reset("t5");
    for (int unsigned i = 0; i < 3; i++) step(2'b10, 4'd0, 4'd6);
    step(2'b00, 4'd0, 4'd6);
`ifdef INTERVAL_ABORT_EN
    check("t5_abort_busy", 32'(bus.busy), 32'd0);
`else
    check("t5_cont_count", 32'(bus.count), 32'd3);
    for (int unsigned i = 0; i < 3; i++) step(2'b00, 4'd0, 4'd6);
    step(2'b00, 4'd0, 4'd6);
    check("t5_done1", 32'(bus.done), 32'd2);
`endif
    for (int unsigned i = 0; i < 3; i++) step(2'b00, 4'd0, 4'd6);

    // Back-to-back intervals for a continuously requesting requester 0.
    do_reset("t6");
    for (int unsigned i = 0; i < 14; i++) step(2'b01, 4'd2, 4'd0);
    step(2'b00, 4'd2, 4'd0);

    // Randomized handshaking requesters.
    do_reset("rnd");
    rq = 2'b00;
    for (int unsigned n = 0; n < 800; n++) begin
      l0 = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      l1 = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      step(rq, l0, l1);
      for (int unsigned i = 0; i < 2; i++) begin
        if (rq[i]) begin
          if (m_exp_done[i]) rq[i] = 1'($urandom_range(0, 1));
        end else begin
          rq[i] = ($urandom_range(0, 3) == 0);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
